point_frame_ctrl: RTL and testbench
===================================

# point_frame_ctrl

Frame-synchronous controller for the pixel-test stage that draws the motion marker. It accepts coordinate samples from the motion-processing path through a valid/ready handshake and buffers the newest one. At the start of each vertical blank it commits that sample to registered outputs that drive the pixel-test inputs (x, y, valid), so the marker never moves mid-frame. It also clamps coordinates to the visible area, blanks the marker when samples stop arriving, and counts samples overwritten before display.

## Interface
- P_DATA_W, 11: coordinate width, same as the pixel-test stage.
- P_SCALE, 2: marker extent in pixels beyond the origin, same as the pixel-test stage.
- P_H_MAX, 1023: last visible column.
- P_V_MAX, 767: last visible row.
- P_STALE_FRAMES, 30: frames without a new commit before the marker blanks; 0 disables the timeout.
- i_clk  in  1  pixel-domain clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_x_val  in  P_DATA_W  sample x coordinate.
- i_y_val  in  P_DATA_W  sample y coordinate.
- i_sample_valid  in  1  sample present this cycle.
- o_sample_ready  out  1  sample accepted when valid and ready are both 1.
- i_vblank  in  1  vertical blank from the timing generator, level.
- i_freeze  in  1  suppresses commits and stale counting while high.
- o_x_val  out  P_DATA_W  committed, clamped x coordinate to the pixel-test stage.
- o_y_val  out  P_DATA_W  committed, clamped y coordinate to the pixel-test stage.
- o_vals_valid  out  1  marker enable to the pixel-test stage.
- o_drop_count  out  8  saturating count of pending samples overwritten before commit.

## Operation
- **Edge detect.** vb_d is a register holding the previous i_vblank. commit_evt = i_vblank & ~vb_d. vb_d resets to 1, so a vblank that is already high when reset releases does not produce an event.
- **Handshake.** o_sample_ready = ~i_rst & ~commit_evt. It is combinational and has no other wait states.
- **Accept.** On an accepted sample, the clamped coordinates are written to the pending register and pend is set to 1.
  - If pend was already 1 and no commit occurs in that cycle, the old sample is overwritten and o_drop_count increments, saturating at 255.
- **Clamp.** The x limit is XL = P_H_MAX − P_SCALE and the y limit is YL = P_V_MAX − P_SCALE.
  - x > XL becomes XL; y > YL becomes YL.
  - Compares use unsigned P_DATA_W+1-bit arithmetic.
  - Clamping is applied at accept time.
- **State machine.** Two states: EMPTY (reset state, o_vals_valid=0) and LIVE (o_vals_valid=1). Transitions happen only on cycles where commit_evt=1 and i_freeze=0:
  - pend=1: o_x_val/o_y_val take the pending value, pend clears, stale_cnt clears, state becomes LIVE. This applies from either state.
  - pend=0 in LIVE with P_STALE_FRAMES≠0: stale_cnt increments. When the incremented value equals P_STALE_FRAMES, state becomes EMPTY and stale_cnt clears. o_x_val/o_y_val hold their last value.
  - pend=0 in EMPTY: no change.
- **Freeze.** When commit_evt=1 and i_freeze=1, the event is consumed (vb_d still updates), but pend, the outputs and stale_cnt are unchanged. Ready is still low in that cycle.
- **Reset.** The following are all 0 during and immediately after reset: o_x_val, o_y_val, o_vals_valid, pend, stale_cnt, o_drop_count. o_sample_ready is 0 while i_rst=1. Reset in mid-frame discards the pending sample.

## Timing
- An accept in cycle N fills pending at the edge ending N, so the sample is eligible for any commit_evt in cycle N+1 or later.
- commit_evt in cycle N makes the new o_x_val, o_y_val and o_vals_valid visible from cycle N+1. This is one register stage and all three change together.
- o_sample_ready is low for exactly one cycle per vblank rising edge. A sample presented in that cycle is held by the source and accepted in cycle N+1.
- i_vblank held high produces only one commit_evt. A one-cycle vblank pulse produces one event.
- The outputs stay stable throughout active video. They change only in the cycle after a commit_evt.

## Test plan
- **Basic commit.** Reset, accept (100,200), then raise vblank at cycle 20 → o_x_val=100, o_y_val=200 and o_vals_valid=1 from cycle 21; all outputs 0 before that.
- **Clamp.** Accept (1023,767) and commit → outputs (1021,765). Accept (0,0) and commit → outputs (0,0).
- **Overwrite.** Accept (10,10), (20,20) and (30,30) within one frame, then commit → outputs (30,30) and o_drop_count=2. Force 300 overwrites → o_drop_count stays at 255.
- **Ready gap.** Hold valid with (50,60) across the vblank rising-edge cycle N → ready=0 in N and acceptance in N+1. The sample is not shown until the following vblank.
- **Stale timeout.** With P_STALE_FRAMES=3, commit (5,5), then run 3 vblanks with no samples → o_vals_valid drops the cycle after the 3rd edge and o_x_val stays 5. Accept a new sample and run the next vblank → o_vals_valid=1.
- **Freeze and reset.** With i_freeze=1 over 5 vblanks and (40,40) pending → no output change and no stale blanking. Release freeze → commit at the next edge. Assert i_rst mid-frame with vblank high → all outputs 0, and no commit when reset releases while vblank is still high.

Source files
------------

// File: rtl/point_frame_ctrl.sv
// point_frame_ctrl
// Buffers the newest motion-marker coordinate sample and commits it to the
// pixel-test stage once per frame, at the rising edge of vertical blank.
// Coordinates are clamped so the marker stays inside the visible area.
// The marker is blanked after P_STALE_FRAMES frames without a new commit.
// Overwritten pending samples are counted with saturation.
//
// Ports:
//   i_clk, i_rst            pixel clock, synchronous active-high reset
//   i_x_val, i_y_val        incoming sample coordinates
//   i_sample_valid          sample present; accepted when o_sample_ready=1
//   o_sample_ready          combinational ready, low in the vblank-edge cycle
//   i_vblank                vertical blank level from the timing generator
//   i_freeze                holds the committed marker and the stale timer
//   o_x_val, o_y_val        committed, clamped coordinates
//   o_vals_valid            marker enable
//   o_drop_count            saturating count of overwritten pending samples
module point_frame_ctrl #(
  parameter int unsigned P_DATA_W       = 11,
  parameter int unsigned P_SCALE        = 2,
  parameter int unsigned P_H_MAX        = 1023,
  parameter int unsigned P_V_MAX        = 767,
  parameter int unsigned P_STALE_FRAMES = 30
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [P_DATA_W-1:0] i_x_val,
  input  logic [P_DATA_W-1:0] i_y_val,
  input  logic                i_sample_valid,
  output logic                o_sample_ready,
  input  logic                i_vblank,
  input  logic                i_freeze,
  output logic [P_DATA_W-1:0] o_x_val,
  output logic [P_DATA_W-1:0] o_y_val,
  output logic                o_vals_valid,
  output logic [7:0]          o_drop_count
);

  localparam int unsigned CMP_W   = P_DATA_W + 1;
  localparam int unsigned STALE_W = (P_STALE_FRAMES < 2) ? 1 : $clog2(P_STALE_FRAMES + 1);

  localparam logic [CMP_W-1:0]   X_LIM     = CMP_W'(P_H_MAX - P_SCALE);
  localparam logic [CMP_W-1:0]   Y_LIM     = CMP_W'(P_V_MAX - P_SCALE);
  localparam logic [STALE_W-1:0] STALE_LIM = STALE_W'(P_STALE_FRAMES);
  localparam bit                 STALE_EN  = (P_STALE_FRAMES != 0);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_LIVE  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic                 vb_d;
  logic                 commit_evt;
  logic                 fire;
  logic                 accept;
  logic                 pend;
  logic [P_DATA_W-1:0]  pend_x;
  logic [P_DATA_W-1:0]  pend_y;
  logic [P_DATA_W-1:0]  x_clamp;
  logic [P_DATA_W-1:0]  y_clamp;
  logic [STALE_W-1:0]   stale_cnt;
  logic [STALE_W-1:0]   stale_inc_val;
  logic                 load_c;
  logic                 stale_step_c;
  logic                 stale_clr_c;

  // vblank rising edge; vb_d resets high so a vblank already high at reset
  // release does not fire.
  assign commit_evt     = i_vblank & ~vb_d;
  assign fire           = commit_evt & ~i_freeze;
  assign o_sample_ready = ~i_rst & ~commit_evt;
  assign accept         = i_sample_valid & o_sample_ready;
  assign stale_inc_val  = stale_cnt + STALE_W'(1);

  // Clamp to the last origin that keeps the whole marker visible.
  assign x_clamp = ({1'b0, i_x_val} > X_LIM) ? P_DATA_W'(X_LIM) : i_x_val;
  assign y_clamp = ({1'b0, i_y_val} > Y_LIM) ? P_DATA_W'(Y_LIM) : i_y_val;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: only a non-frozen commit event moves the FSM.
  always_comb begin
    state_nxt = state;
    if (fire) begin
      if (pend) begin
        state_nxt = ST_LIVE;
      end else if ((state == ST_LIVE) && STALE_EN && (stale_inc_val == STALE_LIM)) begin
        state_nxt = ST_EMPTY;
      end
    end
  end

  // Output / datapath controls decoded from state and the commit event.
  always_comb begin
    load_c       = 1'b0;
    stale_step_c = 1'b0;
    stale_clr_c  = 1'b0;
    if (fire) begin
      if (pend) begin
        load_c      = 1'b1;
        stale_clr_c = 1'b1;
      end else if ((state == ST_LIVE) && STALE_EN) begin
        stale_step_c = 1'b1;
        if (stale_inc_val == STALE_LIM) begin
          stale_clr_c = 1'b1;
        end
      end
    end
  end

  assign o_vals_valid = (state == ST_LIVE);

  // Pending buffer, committed outputs, stale timer and drop counter.
  // Accept and commit never coincide because ready is low on commit_evt.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vb_d         <= 1'b1;
      pend         <= 1'b0;
      pend_x       <= '0;
      pend_y       <= '0;
      stale_cnt    <= '0;
      o_x_val      <= '0;
      o_y_val      <= '0;
      o_drop_count <= '0;
    end else begin
      vb_d <= i_vblank;
      if (load_c) begin
        o_x_val <= pend_x;
        o_y_val <= pend_y;
        pend    <= 1'b0;
      end else if (accept) begin
        pend_x <= x_clamp;
        pend_y <= y_clamp;
        pend   <= 1'b1;
        if (pend && (o_drop_count != 8'hFF)) begin
          o_drop_count <= o_drop_count + 8'd1;
        end
      end
      if (stale_clr_c) begin
        stale_cnt <= '0;
      end else if (stale_step_c) begin
        stale_cnt <= stale_inc_val;
      end
    end
  end

endmodule

// File: tb/tb_point_frame_ctrl.sv
// Testbench for point_frame_ctrl: directed test-plan steps followed by a
// randomized phase, all checked against a frame-level reference model.
module tb_point_frame_ctrl;

  localparam int unsigned DW    = 11;
  localparam int          STALE = 3;
  localparam int          XL    = 1021;
  localparam int          YL    = 765;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [DW-1:0] i_x_val;
  logic [DW-1:0] i_y_val;
  logic          i_sample_valid;
  logic          o_sample_ready;
  logic          i_vblank;
  logic          i_freeze;
  logic [DW-1:0] o_x_val;
  logic [DW-1:0] o_y_val;
  logic          o_vals_valid;
  logic [7:0]    o_drop_count;

  point_frame_ctrl #(
    .P_DATA_W      (DW),
    .P_SCALE       (2),
    .P_H_MAX       (1023),
    .P_V_MAX       (767),
    .P_STALE_FRAMES(STALE)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_x_val       (i_x_val),
    .i_y_val       (i_y_val),
    .i_sample_valid(i_sample_valid),
    .o_sample_ready(o_sample_ready),
    .i_vblank      (i_vblank),
    .i_freeze      (i_freeze),
    .o_x_val       (o_x_val),
    .o_y_val       (o_y_val),
    .o_vals_valid  (o_vals_valid),
    .o_drop_count  (o_drop_count)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: what the pixel-test stage should see, frame by frame.
  int m_x      = 0;
  int m_y      = 0;
  int m_live   = 0;
  int m_pend   = 0;
  int m_px     = 0;
  int m_py     = 0;
  int m_stale  = 0;
  int m_drop   = 0;
  int m_vbprev = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check ready, advance the model, check outputs.
  task automatic cycle(input logic rst, input logic vb, input logic valid,
                       input logic frz, input int x, input int y);
    int evt;
    int rdy;
    i_rst          = rst;
    i_vblank       = vb;
    i_sample_valid = valid;
    i_freeze       = frz;
    i_x_val        = DW'(x);
    i_y_val        = DW'(y);
    #1;
    evt = (!rst && vb && (m_vbprev == 0)) ? 1 : 0;
    rdy = (!rst && (evt == 0)) ? 1 : 0;
    chk("ready", o_sample_ready, rdy);
    if (rst) begin
      m_x = 0; m_y = 0; m_live = 0; m_pend = 0;
      m_stale = 0; m_drop = 0; m_vbprev = 1;
    end else begin
      if ((evt != 0) && !frz) begin
        if (m_pend != 0) begin
          m_x = m_px; m_y = m_py; m_live = 1; m_stale = 0; m_pend = 0;
        end else if (m_live != 0) begin
          m_stale++;
          if (m_stale == STALE) begin
            m_live  = 0;
            m_stale = 0;
          end
        end
      end
      if (valid && (rdy != 0)) begin
        if ((m_pend != 0) && (m_drop < 255)) m_drop++;
        m_pend = 1;
        m_px   = (x > XL) ? XL : x;
        m_py   = (y > YL) ? YL : y;
      end
      m_vbprev = vb ? 1 : 0;
    end
    @(posedge i_clk);
    #1;
    chk("x_val", o_x_val, m_x);
    chk("y_val", o_y_val, m_y);
    chk("vals_valid", o_vals_valid, m_live);
    chk("drop_count", o_drop_count, m_drop);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic send(input int x, input int y);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, x, y);
  endtask

  task automatic vpulse(input int hi, input int lo, input logic frz);
    repeat (hi) cycle(1'b0, 1'b1, 1'b0, frz, 0, 0);
    repeat (lo) cycle(1'b0, 1'b0, 1'b0, frz, 0, 0);
  endtask

  initial begin
    logic r_vb;
    logic r_valid;
    logic r_frz;
    logic r_rst;

    // Reset, then basic commit with vblank rising at cycle 20.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("reset_valid", o_vals_valid, 0);
    send(100, 200);
    idle(17);
    vpulse(3, 5, 1'b0);
    chk("basic_x", o_x_val, 100);
    chk("basic_y", o_y_val, 200);
    chk("basic_valid", o_vals_valid, 1);

    // Clamp at the top corner and at the origin.
    send(1023, 767);
    vpulse(2, 4, 1'b0);
    chk("clamp_x", o_x_val, 1021);
    chk("clamp_y", o_y_val, 765);
    send(0, 0);
    vpulse(2, 4, 1'b0);
    chk("zero_x", o_x_val, 0);

    // Overwrites within one frame, then counter saturation.
    send(10, 10);
    send(20, 20);
    send(30, 30);
    vpulse(2, 4, 1'b0);
    chk("ovw_x", o_x_val, 30);
    chk("ovw_drop", o_drop_count, 2);
    repeat (300) send(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
    chk("drop_sat", o_drop_count, 255);
    vpulse(2, 4, 1'b0);

    // Ready gap: sample held across the vblank edge.
    idle(3);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 50, 60);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 50, 60);
    idle(4);
    vpulse(2, 4, 1'b0);
    chk("gap_x", o_x_val, 50);
    chk("gap_y", o_y_val, 60);

    // Stale timeout after three empty frames.
    send(5, 5);
    vpulse(2, 4, 1'b0);
    vpulse(2, 4, 1'b0);
    vpulse(2, 4, 1'b0);
    chk("stale_live2", o_vals_valid, 1);
    vpulse(1, 4, 1'b0);
    chk("stale_blank", o_vals_valid, 0);
    chk("stale_hold_x", o_x_val, 5);
    send(7, 8);
    vpulse(2, 4, 1'b0);
    chk("stale_revive", o_vals_valid, 1);

    // Freeze over five vblanks, then release.
    send(40, 40);
    repeat (5) vpulse(2, 3, 1'b1);
    chk("frz_x", o_x_val, 7);
    chk("frz_valid", o_vals_valid, 1);
    vpulse(2, 3, 1'b0);
    chk("unfrz_x", o_x_val, 40);

    // Reset mid-frame with vblank high; release while still high.
    send(9, 9);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("rst_x", o_x_val, 0);
    chk("rst_valid", o_vals_valid, 0);
    idle(3);
    vpulse(2, 3, 1'b0);
    chk("rst_discard", o_vals_valid, 0);

    // Randomized traffic.
    r_vb = 1'b0;
    repeat (1500) begin
      if ($urandom_range(0, 9) == 0) r_vb = ~r_vb;
      r_valid = ($urandom_range(0, 3) == 0);
      r_frz   = ($urandom_range(0, 15) == 0);
      r_rst   = ($urandom_range(0, 299) == 0);
      cycle(r_rst, r_vb, r_valid, r_frz,
            int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
